// File: rtl/ps2_scancode_fifo_if.sv
// Read-side port bundle of ps2_scancode_fifo: show-ahead head byte, occupancy and pop request.
// The master modport is the FIFO itself; the slave modport is the consumer.
interface ps2_scancode_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;

    modport master (input rd_en, output rd_data, empty, full, count);
    modport slave  (output rd_en, input rd_data, empty, full, count);
endinterface

// File: rtl/ps2_scancode_fifo.sv
// PS/2 device-to-host receiver with frame checking, show-ahead scancode FIFO and byte history.
// Optional build macro PS2_BREAK_FILTER_EN drops 0xF0 and its follower from the FIFO.
module ps2_scancode_fifo #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned HIST_BYTES     = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kb_clk,
    input  logic                    kb_data,
    input  logic                    clr_err,
    ps2_scancode_fifo_if.master     rd,
    output logic [8*HIST_BYTES-1:0] keycode_hist,
    output logic                    frame_err,
    output logic                    overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = 8 * HIST_BYTES;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   fall_c, data_s;
    logic [TW-1:0]          tmo_cnt;
    logic                   tmo_hit_c;

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift_q, shift_n;
    logic        par_q, par_n;
    logic        accept_c, err_c, push_c;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] count_q, count_n;
    logic [7:0]    rd_data_q, head_n;
    logic          empty_q, full_q;
    logic          pop_c, wr_c, ovf_c;

    // Pin synchronisers idle high so reset never fabricates a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kb_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], kb_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall_c = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Cycles since the last falling edge, saturating at the timeout value
    always_ff @(posedge clk) begin
        if (rst)                              tmo_cnt <= '0;
        else if (fall_c)                      tmo_cnt <= '0;
        else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign tmo_hit_c = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            shift_q <= shift_n;
            par_q   <= par_n;
        end
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        shift_n  = shift_q;
        par_n    = par_q;
        accept_c = 1'b0;
        err_c    = 1'b0;
        if (tmo_hit_c) begin
            state_n = IDLE;
            err_c   = 1'b1;
        end else if (fall_c) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
                DATA: begin
                    shift_n = {data_s, shift_q[7:1]};
                    if (bit_cnt == 3'd7) state_n = PARITY;
                    else                 bit_n   = bit_cnt + 3'd1;
                end
                PARITY: begin
                    par_n   = data_s;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (data_s && (^{shift_q, par_q})) accept_c = 1'b1;
                    else                               err_c    = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic brk_pend;

    // Break prefix and the key code after it are recorded in history only
    always_ff @(posedge clk) begin
        if (rst)           brk_pend <= 1'b0;
        else if (err_c)    brk_pend <= 1'b0;
        else if (accept_c) brk_pend <= brk_pend ? 1'b0 : (shift_q == 8'hF0);
    end

    assign push_c = accept_c && !brk_pend && (shift_q != 8'hF0);
`else
    assign push_c = accept_c;
`endif

    always_ff @(posedge clk) begin
        if (rst)           keycode_hist <= '0;
        else if (accept_c) keycode_hist <= (keycode_hist << 8) | HW'(shift_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= err_c;
            if (ovf_c)        overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

    // Next head is the freshly written byte when it lands at the new read pointer
    always_comb begin
        pop_c    = rd.rd_en && !empty_q;
        wr_c     = push_c && (!full_q || pop_c);
        ovf_c    = push_c && full_q && !pop_c;
        count_n  = count_q + CW'(wr_c) - CW'(pop_c);
        rd_ptr_n = rd_ptr + AW'(pop_c);
        head_n   = (wr_c && (wr_ptr == rd_ptr_n)) ? shift_q : mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (wr_c) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            if (wr_c) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr  <= rd_ptr_n;
            count_q <= count_n;
            empty_q <= (count_n == '0);
            full_q  <= (count_n == CW'(FIFO_DEPTH));
            if (wr_c || pop_c) rd_data_q <= head_n;
        end
    end

    assign rd.rd_data = rd_data_q;
    assign rd.count   = count_q;
    assign rd.empty   = empty_q;
    assign rd.full    = full_q;
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: directed PS/2 frames checked against a queue-based model every quiet cycle.
module tb_ps2_scancode_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned HALF  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kb_clk = 1'b1;
    logic        kb_data = 1'b1;
    logic        clr_err = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] keycode_hist;
    logic        frame_err;
    logic        overflow;

    ps2_scancode_fifo_if #(.FIFO_DEPTH(DEPTH)) rd_if ();
    assign rd_if.rd_en = rd_en;

    ps2_scancode_fifo #(
        .FIFO_DEPTH(DEPTH), .HIST_BYTES(4), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(50000)
    ) dut (
        .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data), .clr_err(clr_err),
        .rd(rd_if.master), .keycode_hist(keycode_hist), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0]  q[$];
    logic [31:0] m_hist = '0;
    bit          m_ovf = 1'b0;
    bit          m_brk = 1'b0;
    bit          quiet = 1'b0;
    bit          prev_fe = 1'b0;
    int          exp_err = 0;
    int          err_pulses = 0;
    int          passed = 0;
    int          total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Byte accepted by the receiver; a same-cycle pop is applied before the push
    task automatic m_accept(input logic [7:0] b, input bit popping);
        m_hist = {m_hist[23:0], b};
        if (popping && q.size() > 0) void'(q.pop_front());
`ifdef PS2_BREAK_FILTER_EN
        if (m_brk) begin
            m_brk = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
`endif
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    always @(negedge clk) begin
        chk("full_vs_count", 32'(rd_if.full), 32'(rd_if.count == 4'(DEPTH)));
        chk("empty_vs_count", 32'(rd_if.empty), 32'(rd_if.count == 4'd0));
        if (frame_err) begin
            err_pulses++;
            chk("frame_err_width", 32'(prev_fe), 32'd0);
        end
        prev_fe = frame_err;
        if (quiet) begin
            chk("count", 32'(rd_if.count), 32'(q.size()));
            chk("empty", 32'(rd_if.empty), 32'(q.size() == 0));
            chk("full", 32'(rd_if.full), 32'(q.size() == DEPTH));
            if (q.size() > 0) chk("rd_data", 32'(rd_if.rd_data), 32'(q[0]));
            chk("hist", keycode_hist, m_hist);
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("frame_err_quiet", 32'(frame_err), 32'd0);
        end
    end

    task automatic ps2_bit(input logic b, input bit pop_at_fall);
        kb_data = b;
        repeat (HALF) @(posedge clk);
        #1 kb_clk = 1'b0;
        if (pop_at_fall) begin
            // rd_en lands on the edge where the stop bit is acted on
            repeat (SYNC) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
            repeat (HALF - SYNC - 1) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nbits, input bit pop_at_stop);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        quiet = 1'b0;
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], pop_at_stop && (i == 10));
        kb_data = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1, 11, 1'b0);
        m_accept(b, 1'b0);
        quiet = 1'b1;
    endtask

    task automatic bad(input logic [7:0] b, input logic par, input logic stop);
        send_frame(b, par, stop, 11, 1'b0);
        exp_err++;
        m_brk = 1'b0;
        quiet = 1'b1;
    endtask

    task automatic do_reset();
        quiet = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_hist = '0;
        m_ovf = 1'b0;
        m_brk = 1'b0;
        quiet = 1'b1;
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        chk("pop_data", 32'(rd_if.rd_data), 32'(exp));
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    initial begin
        do_reset();
        chk("rst_count", 32'(rd_if.count), 32'd0);
        chk("rst_empty", 32'(rd_if.empty), 32'd1);
        chk("rst_full", 32'(rd_if.full), 32'd0);
        chk("rst_rd_data", 32'(rd_if.rd_data), 32'h00);
        chk("rst_hist", keycode_hist, 32'h0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Valid 0x1C
        good(8'h1C);
        chk("t1_rd_data", 32'(rd_if.rd_data), 32'h1C);
        chk("t1_count", 32'(rd_if.count), 32'd1);
        chk("t1_hist", keycode_hist, 32'h0000001C);
        chk("t1_no_err", 32'(err_pulses), 32'd0);

        // Bad parity, bad stop, false start
        do_reset();
        bad(8'h1C, 1'b1, 1'b1);
        chk("t2_err_lit", 32'(err_pulses), 32'd1);
        chk("t2_count", 32'(rd_if.count), 32'd0);
        chk("t2_hist", keycode_hist, 32'h0);
        bad(8'h1C, 1'b0, 1'b0);
        chk("stop0_err", 32'(err_pulses), 32'(exp_err));
        quiet = 1'b0;
        ps2_bit(1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1 quiet = 1'b1;
        chk("false_start_err", 32'(err_pulses), 32'(exp_err));

        // Nine bytes into depth 8
        do_reset();
        for (int i = 1; i <= 9; i++) good(8'(i));
        chk("t3_full", 32'(rd_if.full), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_rd_data", 32'(rd_if.rd_data), 32'h01);
        chk("t3_hist", keycode_hist, 32'h06070809);
        for (int i = 1; i <= 8; i++) pop_chk(8'(i));
        chk("t3_empty", 32'(rd_if.empty), 32'd1);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        m_ovf = 1'b0;
        chk("clr_err", 32'(overflow), 32'd0);

        // Timeout after 5 bits
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
        repeat (50100) @(posedge clk);
        #1 exp_err++;
        quiet = 1'b1;
        chk("t4_tmo_err", 32'(err_pulses), 32'(exp_err));
        good(8'h32);
        chk("t4_rd_data", 32'(rd_if.rd_data), 32'h32);
        chk("t4_count", 32'(rd_if.count), 32'd1);

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 8; i++) good(8'h10 + 8'(i));
        send_frame(8'h2A, ~^8'h2A, 1'b1, 11, 1'b1);
        m_accept(8'h2A, 1'b1);
        quiet = 1'b1;
        chk("t5_count", 32'(rd_if.count), 32'd8);
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_head", 32'(rd_if.rd_data), 32'h11);
        for (int i = 1; i < 8; i++) pop_chk(8'h10 + 8'(i));
        pop_chk(8'h2A);

        // Reset in the middle of a frame
        send_frame(8'h55, 1'b0, 1'b1, 5, 1'b0);
        do_reset();
        good(8'h55);
        chk("midrst_rd_data", 32'(rd_if.rd_data), 32'h55);
        chk("midrst_count", 32'(rd_if.count), 32'd1);

        // Break sequence
        do_reset();
        good(8'hF0);
        good(8'h1C);
        chk("brk_hist", keycode_hist, 32'h0000F01C);
`ifdef PS2_BREAK_FILTER_EN
        chk("brk_empty", 32'(rd_if.empty), 32'd1);
`else
        chk("brk_count", 32'(rd_if.count), 32'd2);
        pop_chk(8'hF0);
        pop_chk(8'h1C);
`endif
        good(8'hE0);
        good(8'hF0);
        bad(8'h00, 1'b0, 1'b1);
        good(8'h1C);
`ifdef PS2_BREAK_FILTER_EN
        chk("brk_err_count", 32'(rd_if.count), 32'd2);
`else
        chk("brk_err_count", 32'(rd_if.count), 32'd3);
`endif
        chk("brk_err_hist", keycode_hist, 32'hF01CE0F0 << 8 | 32'h1C);
        chk("final_err", 32'(err_pulses), 32'(exp_err));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
